fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Sits directly downstream of the fetch stage.
- Takes each PC that fetch produces, issues a read to synchronous instruction memory, and buffers the returned {PC, instruction} pairs in a small FIFO for decode.
- Provides backpressure to fetch (stall) and discards all buffered and in-flight work when a taken branch/jump redirects fetch.

Parameters:
ADDRESS_BITS, 16, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pc_in  input  ADDRESS_BITS  PC from fetch
pc_valid  input  1  pc_in is valid this cycle
pc_ready  output  1  queue accepts pc_in this cycle; fetch holds PC when low
flush  input  1  redirect (next_PC_select taken); kill all queued/in-flight entries
imem_req  output  1  read strobe to instruction memory
imem_addr  output  ADDRESS_BITS  read address
imem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after imem_req
dec_valid  output  1  head entry valid
dec_ready  input  1  decode consumes head entry
dec_pc  output  ADDRESS_BITS  PC of head entry
dec_instr  output  DATA_WIDTH  instruction of head entry
dec_misaligned  output  1  head entry PC had pc[1:0] != 0
count  output  log2(DEPTH)+1  number of valid FIFO entries

Behaviour:
- Reset (reset=0, async):
  - count=0, read/write pointers=0, inflight=0.
  - pc_ready=0 while reset is held.
  - imem_req=0, dec_valid=0; dec_pc, dec_instr and dec_misaligned are 0.
  - FIFO storage contents are don't-care.
- Accept:
  - pc_ready = !flush && (count + inflight) < DEPTH.
  - An accept occurs when pc_valid && pc_ready.
  - On accept, imem_req=1 and imem_addr=pc_in in the same cycle (combinational).
  - pc_in is captured into pending_pc, misaligned = (pc_in[1:0] != 0) is captured, and inflight is set to 1.
  - If there is no accept, imem_req=0; imem_addr still mirrors pc_in.
- Response:
  - On the cycle after an accept, imem_rdata is valid.
  - If inflight=1 and flush=0, {pending_pc, imem_rdata, misaligned} is written at the write pointer and the write pointer increments.
  - inflight is cleared unless a new accept occurs in the same cycle (back-to-back accepts keep inflight=1).
- Drain:
  - dec_valid = (count != 0).
  - dec_* show the entry at the read pointer.
  - A pop occurs when dec_valid && dec_ready; the read pointer increments.
- count:
  - count increments on write-only, decrements on pop-only, and is unchanged on simultaneous write+pop.
- Pointers wrap modulo DEPTH.
- Credit rule: because pc_ready counts inflight, a write never targets a full FIFO. This is an invariant; overflow is impossible by construction.
- Latency and throughput:
  - accept in cycle N -> written at end of cycle N+1 -> dec_valid in cycle N+2.
  - Sustained throughput is 1 instruction per cycle when dec_ready=1.
- Flush (synchronous, single cycle):
  - count=0, pointers=0, inflight=0.
  - Any response arriving in the flush cycle is discarded.
  - pc_ready=0 and no pop occurs in the flush cycle.
  - dec_valid=0 from the next cycle.
  - If flush coincides with pc_valid, that PC is not accepted; fetch re-presents the target PC the following cycle.
- Full:
  - When count + inflight == DEPTH, pc_ready=0.
  - A pop in the same cycle does not raise pc_ready until the next cycle (registered credit, no combinational dec_ready->pc_ready path).
- Empty: a pop attempt with count=0 is ignored (dec_valid=0).
- Reset mid-operation: all state is cleared immediately, and any in-flight response is dropped.
- The misaligned flag is informational only; the entry is still queued.

Test Plan:
- Reset, then pc_valid=1 with pc_in = 0000, 0004, 0008, dec_ready=1, imem returning 00000013/00100093/00200113 -> dec_valid first high 2 cycles after the first accept; dec_pc/instr pairs in order 0000/00000013, 0004/00100093, 0008/00200113; one entry per cycle.
- dec_ready=0, stream PCs 0000..000C -> after 4 accepts pc_ready=0 and count=4; raising dec_ready for 1 cycle -> count=3; pc_ready=1 the following cycle.
- Two entries queued plus one in flight, then flush=1 for 1 cycle -> count=0, dec_valid=0 next cycle; the in-flight rdata is not enqueued; the next PC 0040 emerges as the sole entry.
- flush and pc_valid (pc_in=0020) in the same cycle -> pc_ready=0, imem_req=0; 0020 is presented next cycle, accepted, and decoded with dec_pc=0020.
- pc_in=0002 -> entry has dec_misaligned=1 and dec_pc=0002; the following pc_in=0004 has dec_misaligned=0.
- Assert reset=0 asynchronously mid-stream (between clock edges) with count=2 -> count=0, dec_valid=0, pc_ready=0 immediately; after release, the first accept of PC 0000 behaves as in scenario 1.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: issues one instruction-memory read per accepted PC and buffers the
// returned {PC, instruction, misaligned} entries in a small FIFO for decode.
module fetch_queue #(
   parameter int ADDRESS_BITS = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDRESS_BITS-1:0]   pc_in,
   input  logic                      pc_valid,
   output logic                      pc_ready,
   input  logic                      flush,
   output logic                      imem_req,
   output logic [ADDRESS_BITS-1:0]   imem_addr,
   input  logic [DATA_WIDTH-1:0]     imem_rdata,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [ADDRESS_BITS-1:0]   dec_pc,
   output logic [DATA_WIDTH-1:0]     dec_instr,
   output logic                      dec_misaligned,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDRESS_BITS-1:0] pc;
      logic [DATA_WIDTH-1:0]   instr;
      logic                    misaligned;
   } entry_t;

   entry_t                  mem_q [DEPTH];
   entry_t                  head;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW:0]             count_q, count_d;
   logic                    inflight_q, inflight_d;
   logic [ADDRESS_BITS-1:0] pending_pc_q, pending_pc_d;
   logic                    pending_mis_q, pending_mis_d;
   logic [PW+1:0]           occupancy;
   logic                    accept;
   logic                    write_en;
   logic                    pop;

   // Credit counts the in-flight read, so a response always has a free slot.
   assign occupancy = {1'b0, count_q} + (PW + 2)'(inflight_q);
   assign pc_ready  = reset && !flush && (occupancy < (PW + 2)'(DEPTH));
   assign accept    = pc_valid && pc_ready;
   assign imem_req  = accept;
   assign imem_addr = pc_in;

   assign write_en  = inflight_q && !flush;
   assign dec_valid = (count_q != '0);
   assign pop       = dec_valid && dec_ready && !flush;

   assign head           = mem_q[rd_ptr_q];
   assign dec_pc         = dec_valid ? head.pc         : '0;
   assign dec_instr      = dec_valid ? head.instr      : '0;
   assign dec_misaligned = dec_valid ? head.misaligned : 1'b0;
   assign count          = count_q;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      inflight_d    = accept;
      pending_pc_d  = accept ? pc_in : pending_pc_q;
      pending_mis_d = accept ? (pc_in[1:0] != 2'b00) : pending_mis_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (write_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({write_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: control state uses non-blocking assignments and async reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         pending_pc_q  <= '0;
         pending_mis_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         pending_pc_q  <= pending_pc_d;
         pending_mis_q <= pending_mis_d;
      end
   end

   // NOTE: storage is deliberately not reset; dec_valid masks stale contents.
   always_ff @(posedge clock) begin
      if (write_en) mem_q[wr_ptr_q] <= '{pc: pending_pc_q, instr: imem_rdata, misaligned: pending_mis_q};
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int AB    = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic                    clock;
   logic                    reset;
   logic [AB-1:0]           pc_in;
   logic                    pc_valid;
   logic                    pc_ready;
   logic                    flush;
   logic                    imem_req;
   logic [AB-1:0]           imem_addr;
   logic [DW-1:0]           imem_rdata;
   logic                    dec_valid;
   logic                    dec_ready;
   logic [AB-1:0]           dec_pc;
   logic [DW-1:0]           dec_instr;
   logic                    dec_misaligned;
   logic [$clog2(DEPTH):0]  count;

   fetch_queue #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr),
      .dec_misaligned (dec_misaligned),
      .count          (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [AB-1:0] pc;
      logic [DW-1:0] instr;
      logic          mis;
   } ment_t;

   ment_t         mq[$];
   logic          m_inflight;
   logic [AB-1:0] m_pend;
   int            n_cmp;
   int            n_err;

   function automatic logic [DW-1:0] mem_fn(input logic [AB-1:0] a);
      case (a)
         16'h0000: return 32'h0000_0013;
         16'h0004: return 32'h0010_0093;
         16'h0008: return 32'h0020_0113;
         default:  return {a ^ 16'hA5C3, ~a};
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_inflight = 1'b0;
   endtask

   // One clock: apply inputs, compare combinational/registered outputs, advance model.
   task automatic step(input logic pv, input logic [AB-1:0] pc, input logic dr, input logic fl);
      logic exp_ready;
      logic exp_acc;
      pc_valid  = pv;
      pc_in     = pc;
      dec_ready = dr;
      flush     = fl;
      #1;
      exp_ready = reset && !fl && ((mq.size() + int'(m_inflight)) < DEPTH);
      exp_acc   = pv && exp_ready;
      check("pc_ready",  64'(pc_ready),  64'(exp_ready));
      check("imem_req",  64'(imem_req),  64'(exp_acc));
      check("imem_addr", 64'(imem_addr), 64'(pc));
      check("count",     64'(count),     64'(mq.size()));
      check("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("dec_pc",    64'(dec_pc),         64'(mq[0].pc));
         check("dec_instr", 64'(dec_instr),      64'(mq[0].instr));
         check("dec_mis",   64'(dec_misaligned), 64'(mq[0].mis));
      end
      @(posedge clock);
      if (!reset || fl) begin
         model_clear();
      end else begin
         if (mq.size() != 0 && dr) void'(mq.pop_front());
         if (m_inflight) mq.push_back('{pc: m_pend, instr: mem_fn(m_pend), mis: (m_pend[1:0] != 2'b00)});
         m_inflight = exp_acc;
         if (exp_acc) m_pend = pc;
      end
      #1;
      imem_rdata = exp_acc ? mem_fn(pc) : DW'($urandom);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b0;
      pc_valid   = 1'b1;
      pc_in      = 16'h0000;
      flush      = 1'b0;
      dec_ready  = 1'b1;
      imem_rdata = '0;
      m_inflight = 1'b0;
      m_pend     = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_count",     64'(count),          64'd0);
      check("rst_pc_ready",  64'(pc_ready),       64'd0);
      check("rst_imem_req",  64'(imem_req),       64'd0);
      check("rst_dec_valid", 64'(dec_valid),      64'd0);
      check("rst_dec_pc",    64'(dec_pc),         64'd0);
      check("rst_dec_instr", 64'(dec_instr),      64'd0);
      check("rst_dec_mis",   64'(dec_misaligned), 64'd0);
      reset = 1'b1;

      // Streaming: three PCs back to back, decode always ready.
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      check("s1_lat_n1", 64'(dec_valid), 64'd0);
      step(1'b1, 16'h0004, 1'b1, 1'b0);
      check("s1_lat_n2", 64'(dec_valid), 64'd1);
      check("s1_pc0",    64'(dec_pc),    64'h0000);
      step(1'b1, 16'h0008, 1'b1, 1'b0);
      check("s1_instr1", 64'(dec_instr), 64'h0010_0093);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("s1_instr2", 64'(dec_instr), 64'h0020_0113);
      drain(3);

      // Fill to full with decode stalled, then one pop frees one credit.
      for (int i = 0; i < 6; i++) step(1'b1, 16'(i * 4), 1'b0, 1'b0);
      check("s2_full_count", 64'(count),    64'd4);
      check("s2_full_ready", 64'(pc_ready), 64'd0);
      step(1'b1, 16'h0010, 1'b1, 1'b0);
      check("s2_pop_count",  64'(count),    64'd3);
      check("s2_pop_ready",  64'(pc_ready), 64'd1);
      drain(5);

      // Flush with two queued and one in flight.
      step(1'b1, 16'h0100, 1'b0, 1'b0);
      step(1'b1, 16'h0104, 1'b0, 1'b0);
      step(1'b1, 16'h0108, 1'b0, 1'b0);
      check("s3_pre_count", 64'(count), 64'd2);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("s3_count",     64'(count),     64'd0);
      check("s3_dec_valid", 64'(dec_valid), 64'd0);
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("s3_sole_count", 64'(count),  64'd1);
      check("s3_sole_pc",    64'(dec_pc), 64'h0040);
      drain(2);

      // Flush coinciding with a valid PC, which is re-presented next cycle.
      step(1'b1, 16'h0020, 1'b1, 1'b1);
      step(1'b1, 16'h0020, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("s4_pc", 64'(dec_pc), 64'h0020);
      drain(2);

      // Misaligned PC followed by an aligned one.
      step(1'b1, 16'h0002, 1'b0, 1'b0);
      step(1'b1, 16'h0004, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("s5_mis_pc", 64'(dec_pc),         64'h0002);
      check("s5_mis",    64'(dec_misaligned), 64'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("s5_ali_mis", 64'(dec_misaligned), 64'd0);
      drain(2);

      // Asynchronous reset between edges with two entries queued and one in flight.
      step(1'b1, 16'h0200, 1'b0, 1'b0);
      step(1'b1, 16'h0204, 1'b0, 1'b0);
      step(1'b1, 16'h0208, 1'b0, 1'b0);
      check("s6_pre_count", 64'(count), 64'd2);
      pc_valid = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("s6_count",     64'(count),     64'd0);
      check("s6_dec_valid", 64'(dec_valid), 64'd0);
      check("s6_pc_ready",  64'(pc_ready),  64'd0);
      check("s6_imem_req",  64'(imem_req),  64'd0);
      model_clear();
      @(posedge clock);
      #1;
      step(1'b1, 16'h0300, 1'b1, 1'b0);
      reset = 1'b1;
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      check("s6_lat_n1", 64'(dec_valid), 64'd0);
      step(1'b1, 16'h0004, 1'b1, 1'b0);
      check("s6_lat_n2", 64'(dec_valid), 64'd1);
      check("s6_instr0", 64'(dec_instr), 64'h0000_0013);
      drain(3);

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic [AB-1:0] rpc;
         rpc = AB'($urandom);
         if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
         step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      end
      drain(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "bench timed out");
   end

endmodule
